mem_responder: RTL and testbench

- Target-side memory model for the CPU's instruction and data memory ports. It accepts read and write requests over the same ready/valid interface the pipeline drives.
- Reads return data in order after a fixed pipeline latency, through a response queue that absorbs consumer backpressure.
- Writes commit on acceptance and produce no response.
- Instantiated twice: once as imem (read-only use), once as dmem.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_responder_if.sv | 24 ++
 rtl/resp_fifo.sv | 60 ++++++
 rtl/mem_responder.sv | 118 +++++++++++
 tb/tb_mem_responder.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

   localparam int unsigned WORD_W = 32;

   typedef enum logic {
      CACHE_READ  = 1'b0,
      CACHE_WRITE = 1'b1
   } cache_op_e;

   // One delay-line slot carrying a read result towards the response queue.
   typedef struct packed {
      logic              valid;
      logic [WORD_W-1:0] data;
   } resp_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between a pipeline port and mem_responder.
interface mem_responder_if;
   import mem_pkg::*;

   logic              valid_in;
   logic              ready_in;
   logic [31:0]       addr_in;
   logic              op_in;
   logic [WORD_W-1:0] write_data_in;
   logic              ready_out;
   logic              valid_out;
   logic [WORD_W-1:0] data_out;

   modport slave (
      input  valid_in, addr_in, op_in, write_data_in, ready_out,
      output ready_in, valid_out, data_out
   );

   modport master (
      output valid_in, addr_in, op_in, write_data_in, ready_out,
      input  ready_in, valid_out, data_out
   );

endinterface

// File: rtl/resp_fifo.sv
// Synchronous FIFO with registered head (zero when empty); caller must not enqueue when full.
module resp_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_enq,
   input  logic [WIDTH-1:0]       i_enq_data,
   input  logic                   i_deq,
   output logic [WIDTH-1:0]       o_head,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr;
   logic [AW:0]      r_rd;
   logic [WIDTH-1:0] r_head;
   logic [AW:0]      w_wr_nxt;
   logic [AW:0]      w_rd_nxt;
   logic             w_do_deq;

   assign o_empty  = (r_wr == r_rd);
   assign o_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign o_count  = r_wr - r_rd;
   assign o_head   = r_head;
   assign w_do_deq = i_deq && !o_empty;
   assign w_wr_nxt = r_wr + (AW+1)'(i_enq);
   assign w_rd_nxt = r_rd + (AW+1)'(w_do_deq);

   always_ff @(posedge clk) begin
      if (i_enq) begin
         r_mem[r_wr[AW-1:0]] <= i_enq_data;
      end
   end

   // Head is precomputed for the post-edge state; bypass covers the slot written this edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr   <= '0;
         r_rd   <= '0;
         r_head <= '0;
      end else begin
         r_wr <= w_wr_nxt;
         r_rd <= w_rd_nxt;
         if (w_wr_nxt == w_rd_nxt) begin
            r_head <= '0;
         end else if (i_enq && (w_rd_nxt == r_wr)) begin
            r_head <= i_enq_data;
         end else begin
            r_head <= r_mem[w_rd_nxt[AW-1:0]];
         end
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Target-side word memory with in-order, credit-limited read responses.
// Optional random backpressure when MEM_RESPONDER_STALL_EN is defined.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned RESP_DEPTH = 4
) (
   input  logic           clk,
   input  logic           reset,
   mem_responder_if.slave bus
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(RESP_DEPTH) + 1;

   logic [WORD_W-1:0] r_mem [DEPTH];

   logic [IW-1:0]     w_idx;
   logic              w_accept;
   logic              w_rd_acc;
   logic              w_wr_acc;
   logic              w_enq;
   logic [WORD_W-1:0] w_enq_data;
   logic              w_deq;
   logic              w_can_accept;
   logic              w_can_deq;
   logic [WORD_W-1:0] w_head;
   logic              w_full;
   logic              w_empty;
   logic [CW-1:0]     w_count;
   logic [CW-1:0]     w_inflight;
   logic [CW-1:0]     w_outstanding;

   assign w_idx    = bus.addr_in[2 +: IW];
   assign w_accept = bus.valid_in && bus.ready_in;
   assign w_rd_acc = w_accept && (bus.op_in == CACHE_READ);
   assign w_wr_acc = w_accept && (bus.op_in == CACHE_WRITE);

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[w_idx] <= bus.write_data_in;
      end
   end

   if (LATENCY == 1) begin : g_nodly
      assign w_enq      = w_rd_acc;
      assign w_enq_data = r_mem[w_idx];
      assign w_inflight = '0;
   end else begin : g_dly
      resp_t r_dly [LATENCY-1];

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int unsigned i = 0; i < LATENCY-1; i++) begin
               r_dly[i].valid <= 1'b0;
            end
         end else begin
            r_dly[0] <= '{valid: w_rd_acc, data: r_mem[w_idx]};
            for (int unsigned i = 1; i < LATENCY-1; i++) begin
               r_dly[i] <= r_dly[i-1];
            end
         end
      end

      always_comb begin
         w_inflight = '0;
         for (int unsigned i = 0; i < LATENCY-1; i++) begin
            w_inflight = w_inflight + CW'(r_dly[i].valid);
         end
      end

      assign w_enq      = r_dly[LATENCY-2].valid;
      assign w_enq_data = r_dly[LATENCY-2].data;
   end

`ifdef MEM_RESPONDER_STALL_EN
   logic [15:0] r_lfsr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_lfsr <= 16'hACE1;
      end else begin
         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      end
   end

   assign w_can_accept = (r_lfsr[1:0] != 2'b00);
   assign w_can_deq    = (r_lfsr[3:2] != 2'b00);
`else
   assign w_can_accept = 1'b1;
   assign w_can_deq    = 1'b1;
`endif

   // Credits cover both queued and in-flight reads, so the queue cannot overflow.
   assign w_outstanding = w_count + w_inflight;
   assign bus.ready_in  = !reset && (w_outstanding < CW'(RESP_DEPTH)) && w_can_accept;
   assign bus.valid_out = !w_empty;
   assign bus.data_out  = w_head;
   assign w_deq         = bus.valid_out && bus.ready_out && w_can_deq;

   resp_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (RESP_DEPTH)
   ) u_resp_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_enq      (w_enq && !w_full),
      .i_enq_data (w_enq_data),
      .i_deq      (w_deq),
      .o_head     (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (w_count)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (default build, LATENCY=2, RESP_DEPTH=4).
module tb_mem_responder;
   import mem_pkg::*;

   localparam int unsigned DEPTH      = 1024;
   localparam int unsigned LATENCY    = 2;
   localparam int unsigned RESP_DEPTH = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   mem_responder_if bus ();

   mem_responder #(
      .DEPTH      (DEPTH),
      .LATENCY    (LATENCY),
      .RESP_DEPTH (RESP_DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          errors   = 0;
   int          checks   = 0;
   int          tb_out   = 0;
   int          acc_cnt  = 0;
   int          resp_cnt = 0;
   logic [31:0] exp_q [$];
   logic [31:0] model [DEPTH];

   task automatic drive(input logic v, input logic op, input logic [31:0] a,
                        input logic [31:0] wd, input logic ro);
      bus.valid_in      = v;
      bus.op_in         = op;
      bus.addr_in       = a;
      bus.write_data_in = wd;
      bus.ready_out     = ro;
   endtask

   // One cycle: inputs already driven at the falling edge; sample, score, advance.
   task automatic step();
      logic        acc;
      logic        deq;
      logic        exp_rdy;
      logic [31:0] e;
      int          idx;
      #1;
      exp_rdy = (!reset && tb_out < int'(RESP_DEPTH));
      checks++;
      if (bus.ready_in !== exp_rdy) begin
         errors++;
         $display("FAIL credit_ready_in got=%b exp=%b out=%0d", bus.ready_in, exp_rdy, tb_out);
      end
      acc = bus.valid_in && bus.ready_in;
      deq = bus.valid_out && bus.ready_out;
      idx = int'(bus.addr_in[11:2]);
      if (deq === 1'b1) begin
         checks++;
         resp_cnt++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_response got=%h exp=none", bus.data_out);
         end else begin
            e = exp_q.pop_front();
            if (bus.data_out !== e) begin
               errors++;
               $display("FAIL response_data got=%h exp=%h", bus.data_out, e);
            end
         end
      end
      if (reset) begin
         exp_q.delete();
         tb_out = 0;
      end else begin
         if (acc === 1'b1) begin
            acc_cnt++;
            if (bus.op_in == CACHE_READ) begin
               exp_q.push_back(model[idx]);
               tb_out++;
            end else begin
               model[idx] = bus.write_data_in;
            end
         end
         if (deq === 1'b1) tb_out--;
      end
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      drive(1'b0, CACHE_READ, '0, '0, 1'b1);
      while (exp_q.size() > 0 && n < 50) begin
         step();
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || bus.valid_out !== 1'b0) begin
         errors++;
         $display("FAIL drain left=%0d valid_out=%b exp=0", exp_q.size(), bus.valid_out);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, CACHE_READ, '0, '0, 1'b1);
      step();
      step();
      checks++;
      if (bus.valid_out !== 1'b0 || bus.data_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs got=%b/%h exp=0/0", bus.valid_out, bus.data_out);
      end
      reset = 1'b0;
      for (int i = 0; i < 64; i++) begin
         drive(1'b1, CACHE_WRITE, 32'(i * 4), 32'h1000_0000 + 32'(i * 7), 1'b1);
         step();
      end
      drive(1'b0, CACHE_READ, '0, '0, 1'b1);
      step();
   endtask

   task automatic test_write_read();
      int n = 0;
      drive(1'b1, CACHE_WRITE, 32'h10, 32'hDEADBEEF, 1'b1);
      step();
      checks++;
      if (bus.valid_out !== 1'b0) begin
         errors++;
         $display("FAIL write_no_response got=%b exp=0", bus.valid_out);
      end
      drive(1'b1, CACHE_READ, 32'h10, '0, 1'b1);
      step();
      drive(1'b0, CACHE_READ, '0, '0, 1'b1);
      while (bus.valid_out !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      checks++;
      if (n != int'(LATENCY) - 1 || bus.data_out !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL read_latency got=%0d/%h exp=%0d/deadbeef", n, bus.data_out, LATENCY - 1);
      end
      drain();
   endtask

   task automatic test_in_order();
      int r0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, CACHE_WRITE, 32'(i * 4), 32'(i + 1), 1'b1);
         step();
      end
      r0 = resp_cnt;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, CACHE_READ, 32'(i * 4), '0, 1'b1);
         step();
      end
      drive(1'b0, CACHE_READ, '0, '0, 1'b1);
      checks++;
      if (resp_cnt - r0 != 1 || bus.valid_out !== 1'b1 || bus.data_out !== 32'd2) begin
         errors++;
         $display("FAIL in_order_first got=%0d/%h exp=1/2", resp_cnt - r0, bus.data_out);
      end
      step();
      step();
      checks++;
      if (resp_cnt - r0 != 3 || bus.valid_out !== 1'b0 || bus.data_out !== 32'h0) begin
         errors++;
         $display("FAIL in_order_done got=%0d/%b/%h exp=3/0/0", resp_cnt - r0, bus.valid_out, bus.data_out);
      end
   endtask

   task automatic test_backpressure();
      int a0 = acc_cnt;
      int r0 = resp_cnt;
      logic [31:0] first;
      first = model[32];
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, CACHE_READ, 32'h80 + 32'(i * 4), '0, 1'b0);
         step();
      end
      checks++;
      if (acc_cnt - a0 != int'(RESP_DEPTH) || bus.ready_in !== 1'b0) begin
         errors++;
         $display("FAIL bp_accepts got=%0d/%b exp=%0d/0", acc_cnt - a0, bus.ready_in, RESP_DEPTH);
      end
      checks++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== first) begin
         errors++;
         $display("FAIL bp_hold got=%b/%h exp=1/%h", bus.valid_out, bus.data_out, first);
      end
      drive(1'b0, CACHE_READ, '0, '0, 1'b1);
      step();
      checks++;
      if (bus.ready_in !== 1'b1) begin
         errors++;
         $display("FAIL bp_credit_return got=%b exp=1", bus.ready_in);
      end
      drain();
      checks++;
      if (resp_cnt - r0 != int'(RESP_DEPTH)) begin
         errors++;
         $display("FAIL bp_resp_count got=%0d exp=%0d", resp_cnt - r0, RESP_DEPTH);
      end
   endtask

   task automatic test_reset_inflight();
      int r0;
      drive(1'b1, CACHE_WRITE, 32'h44, 32'hCAFE0044, 1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, CACHE_READ, 32'h40, '0, 1'b0);
         step();
      end
      reset = 1'b1;
      drive(1'b0, CACHE_READ, '0, '0, 1'b0);
      step();
      reset = 1'b0;
      checks++;
      if (bus.valid_out !== 1'b0 || bus.data_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_flush got=%b/%h exp=0/0", bus.valid_out, bus.data_out);
      end
      r0 = resp_cnt;
      drive(1'b0, CACHE_READ, '0, '0, 1'b1);
      for (int i = 0; i < 6; i++) step();
      checks++;
      if (resp_cnt != r0) begin
         errors++;
         $display("FAIL stale_response got=%0d exp=0", resp_cnt - r0);
      end
      drive(1'b1, CACHE_READ, 32'h44, '0, 1'b1);
      step();
      drive(1'b0, CACHE_READ, '0, '0, 1'b1);
      step();
      checks++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== 32'hCAFE0044) begin
         errors++;
         $display("FAIL mem_after_reset got=%b/%h exp=1/cafe0044", bus.valid_out, bus.data_out);
      end
      drain();
   endtask

   task automatic test_alias();
      int n = 0;
      drive(1'b1, CACHE_WRITE, 32'h0, 32'h5, 1'b1);
      step();
      drive(1'b1, CACHE_READ, 32'h1003, '0, 1'b1);
      step();
      drive(1'b0, CACHE_READ, '0, '0, 1'b1);
      while (bus.valid_out !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      checks++;
      if (bus.data_out !== 32'h5) begin
         errors++;
         $display("FAIL alias_read got=%h exp=00000005", bus.data_out);
      end
      drain();
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic        pv;
      logic        pr;
      logic [31:0] pd;
      for (int i = 0; i < 400; i++) begin
         a = $urandom();
         a[11:8] = 4'h0;
         drive($urandom_range(0, 3) != 0, CACHE_READ, a, $urandom(), $urandom_range(0, 2) != 0);
         if ($urandom_range(0, 3) == 0) bus.op_in = CACHE_WRITE;
         pv = bus.valid_out;
         pr = bus.ready_out;
         pd = bus.data_out;
         step();
         if (pv && !pr) begin
            checks++;
            if (bus.valid_out !== 1'b1 || bus.data_out !== pd) begin
               errors++;
               $display("FAIL stall_hold got=%b/%h exp=1/%h", bus.valid_out, bus.data_out, pd);
            end
         end
      end
      drain();
   endtask

   initial begin
      drive(1'b0, CACHE_READ, '0, '0, 1'b1);
      @(negedge clk);
      test_reset();
      test_write_read();
      test_in_order();
      test_backpressure();
      test_reset_inflight();
      test_alias();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
